// File: rtl/rs_wakeup_select_pkg.sv
// rs_wakeup_select_pkg: opcode encodings and class helpers shared by the reservation station
package rs_wakeup_select_pkg;

    localparam int OPENUM_W = 6;

    typedef enum logic [OPENUM_W-1:0] {
        OPENUM_NOP   = 6'd0,
        OPENUM_LUI   = 6'd1,
        OPENUM_AUIPC = 6'd2,
        OPENUM_JAL   = 6'd3,
        OPENUM_JALR  = 6'd4,
        OPENUM_BEQ   = 6'd5,
        OPENUM_BNE   = 6'd6,
        OPENUM_BLT   = 6'd7,
        OPENUM_BGE   = 6'd8,
        OPENUM_BLTU  = 6'd9,
        OPENUM_BGEU  = 6'd10,
        OPENUM_LB    = 6'd11,
        OPENUM_LH    = 6'd12,
        OPENUM_LW    = 6'd13,
        OPENUM_LBU   = 6'd14,
        OPENUM_LHU   = 6'd15,
        OPENUM_SB    = 6'd16,
        OPENUM_SH    = 6'd17,
        OPENUM_SW    = 6'd18,
        OPENUM_ADDI  = 6'd19,
        OPENUM_SLTI  = 6'd20,
        OPENUM_SLTIU = 6'd21,
        OPENUM_XORI  = 6'd22,
        OPENUM_ORI   = 6'd23,
        OPENUM_ANDI  = 6'd24,
        OPENUM_SLLI  = 6'd25,
        OPENUM_SRLI  = 6'd26,
        OPENUM_SRAI  = 6'd27,
        OPENUM_ADD   = 6'd28,
        OPENUM_SUB   = 6'd29,
        OPENUM_SLL   = 6'd30,
        OPENUM_SLT   = 6'd31,
        OPENUM_SLTU  = 6'd32,
        OPENUM_XOR   = 6'd33,
        OPENUM_SRL   = 6'd34,
        OPENUM_SRA   = 6'd35,
        OPENUM_OR    = 6'd36,
        OPENUM_AND   = 6'd37
    } openum_e;

    localparam logic [OPENUM_W-1:0] BR_FIRST     = OPENUM_BEQ;
    localparam logic [OPENUM_W-1:0] BR_LAST      = OPENUM_BGEU;
    localparam logic [OPENUM_W-1:0] IMM_OP_FIRST = OPENUM_ADDI;
    localparam logic [OPENUM_W-1:0] IMM_OP_LAST  = OPENUM_SRAI;

    function automatic logic is_branch(input logic [OPENUM_W-1:0] op);
        return op >= BR_FIRST && op <= BR_LAST;
    endfunction

    function automatic logic uses_imm(input logic [OPENUM_W-1:0] op);
        return (op >= IMM_OP_FIRST && op <= IMM_OP_LAST) || op == OPENUM_LUI || op == OPENUM_AUIPC;
    endfunction

endpackage

// File: rtl/rs_wakeup_select_pick.sv
// rs_priority_pick: finds the lowest set bit of a request mask
module rs_priority_pick #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);

    // scan from the top so the lowest requesting index is the last one written
    always_comb begin
        found_o = |req_i;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) idx_o = i[IW-1:0];
    end
endmodule

// File: rtl/rs_wakeup_select.sv
// rs_wakeup_select: reservation station with CDB wakeup and dual ALU/branch lowest-index issue
module rs_wakeup_select
    import rs_wakeup_select_pkg::*;
#(
    parameter int RS_SIZE    = 16,
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int OPENUM_LEN = 6,
    parameter int ROB_LEN    = 4,
    parameter int CDB_PORTS  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          dsp_valid,
    input  logic [OPENUM_LEN-1:0]         openum_from_dsp,
    input  logic [DATA_LEN-1:0]           V1_from_dsp,
    input  logic [DATA_LEN-1:0]           V2_from_dsp,
    input  logic [ROB_LEN-1:0]            Q1_from_dsp,
    input  logic [ROB_LEN-1:0]            Q2_from_dsp,
    input  logic [ADDR_LEN-1:0]           pc_from_dsp,
    input  logic [DATA_LEN-1:0]           imm_from_dsp,
    input  logic [ROB_LEN-1:0]            rob_id_from_dsp,
    output logic                          full_to_dsp,
    input  logic [CDB_PORTS-1:0]          cdb_valid,
    input  logic [CDB_PORTS*ROB_LEN-1:0]  cdb_tag,
    input  logic [CDB_PORTS*DATA_LEN-1:0] cdb_value,
    output logic                          al_valid,
    output logic [OPENUM_LEN-1:0]         openum_to_al,
    output logic [DATA_LEN-1:0]           oprand1_to_al,
    output logic [DATA_LEN-1:0]           oprand2_to_al,
    output logic [ADDR_LEN-1:0]           pc_to_al,
    output logic [ROB_LEN-1:0]            rob_id_to_al,
    output logic                          br_valid,
    output logic [OPENUM_LEN-1:0]         openum_to_br,
    output logic [DATA_LEN-1:0]           oprand1_to_br,
    output logic [DATA_LEN-1:0]           oprand2_to_br,
    output logic [DATA_LEN-1:0]           offset_to_br,
    output logic [ADDR_LEN-1:0]           pc_to_br,
    output logic [ROB_LEN-1:0]            rob_id_to_br
);
    localparam int IW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]    busy_q, busy_d;
    logic [OPENUM_LEN-1:0] op_q  [RS_SIZE];
    logic [OPENUM_LEN-1:0] op_d  [RS_SIZE];
    logic [DATA_LEN-1:0]   v1_q  [RS_SIZE];
    logic [DATA_LEN-1:0]   v1_d  [RS_SIZE];
    logic [DATA_LEN-1:0]   v2_q  [RS_SIZE];
    logic [DATA_LEN-1:0]   v2_d  [RS_SIZE];
    logic [ROB_LEN-1:0]    q1_q  [RS_SIZE];
    logic [ROB_LEN-1:0]    q1_d  [RS_SIZE];
    logic [ROB_LEN-1:0]    q2_q  [RS_SIZE];
    logic [ROB_LEN-1:0]    q2_d  [RS_SIZE];
    logic [ADDR_LEN-1:0]   pc_q  [RS_SIZE];
    logic [ADDR_LEN-1:0]   pc_d  [RS_SIZE];
    logic [DATA_LEN-1:0]   imm_q [RS_SIZE];
    logic [DATA_LEN-1:0]   imm_d [RS_SIZE];
    logic [ROB_LEN-1:0]    rob_q [RS_SIZE];
    logic [ROB_LEN-1:0]    rob_d [RS_SIZE];

    logic [DATA_LEN:0]     wake1 [RS_SIZE];
    logic [DATA_LEN:0]     wake2 [RS_SIZE];
    logic [DATA_LEN:0]     fwd1, fwd2;
    logic [RS_SIZE-1:0]    al_req, br_req;
    logic                  free_found, al_found, br_found, ins;
    logic [IW-1:0]         free_idx, al_idx, br_idx;

    logic                  al_valid_q, al_valid_d, br_valid_q, br_valid_d;
    logic [OPENUM_LEN-1:0] al_op_q, al_op_d, br_op_q, br_op_d;
    logic [DATA_LEN-1:0]   al_o1_q, al_o1_d, al_o2_q, al_o2_d;
    logic [DATA_LEN-1:0]   br_o1_q, br_o1_d, br_o2_q, br_o2_d, br_off_q, br_off_d;
    logic [ADDR_LEN-1:0]   al_pc_q, al_pc_d, br_pc_q, br_pc_d;
    logic [ROB_LEN-1:0]    al_rob_q, al_rob_d, br_rob_q, br_rob_d;

    // {hit, value} for a tag; tag 0 never matches and the lowest matching port wins
    function automatic logic [DATA_LEN:0] cdb_lookup(
        input logic [ROB_LEN-1:0]            tag,
        input logic [CDB_PORTS-1:0]          vld,
        input logic [CDB_PORTS*ROB_LEN-1:0]  tags,
        input logic [CDB_PORTS*DATA_LEN-1:0] vals
    );
        logic [DATA_LEN:0] r;
        r = '0;
        for (int p = CDB_PORTS - 1; p >= 0; p--)
            if (tag != '0 && vld[p] && tags[p*ROB_LEN +: ROB_LEN] == tag)
                r = {1'b1, vals[p*DATA_LEN +: DATA_LEN]};
        return r;
    endfunction

    assign full_to_dsp = &busy_q;
    assign ins = dsp_valid && !full_to_dsp && !flush;
    assign fwd1 = cdb_lookup(Q1_from_dsp, cdb_valid, cdb_tag, cdb_value);
    assign fwd2 = cdb_lookup(Q2_from_dsp, cdb_valid, cdb_tag, cdb_value);

    // per-entry CDB match and per-class readiness, all from pre-edge state
    always_comb begin
        al_req = '0;
        br_req = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wake1[i] = cdb_lookup(q1_q[i], cdb_valid, cdb_tag, cdb_value);
            wake2[i] = cdb_lookup(q2_q[i], cdb_valid, cdb_tag, cdb_value);
            al_req[i] = busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0 && !is_branch(op_q[i]);
            br_req[i] = busy_q[i] && q1_q[i] == '0 && q2_q[i] == '0 && is_branch(op_q[i]);
        end
    end

    rs_priority_pick #(.N(RS_SIZE)) u_free_pick (.req_i(~busy_q), .found_o(free_found), .idx_o(free_idx));
    rs_priority_pick #(.N(RS_SIZE)) u_al_pick   (.req_i(al_req),  .found_o(al_found),   .idx_o(al_idx));
    rs_priority_pick #(.N(RS_SIZE)) u_br_pick   (.req_i(br_req),  .found_o(br_found),   .idx_o(br_idx));

    // entry next state: wakeup, issue release, insert with same-cycle forwarding, flush last
    always_comb begin
        busy_d = busy_q;
        op_d = op_q;
        v1_d = v1_q;
        v2_d = v2_q;
        q1_d = q1_q;
        q2_d = q2_q;
        pc_d = pc_q;
        imm_d = imm_q;
        rob_d = rob_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && wake1[i][DATA_LEN]) begin
                v1_d[i] = wake1[i][DATA_LEN-1:0];
                q1_d[i] = '0;
            end
            if (busy_q[i] && wake2[i][DATA_LEN]) begin
                v2_d[i] = wake2[i][DATA_LEN-1:0];
                q2_d[i] = '0;
            end
        end
        if (al_found) busy_d[al_idx] = 1'b0;
        if (br_found) busy_d[br_idx] = 1'b0;
        if (ins && free_found) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx] = openum_from_dsp;
            v1_d[free_idx] = fwd1[DATA_LEN] ? fwd1[DATA_LEN-1:0] : V1_from_dsp;
            v2_d[free_idx] = fwd2[DATA_LEN] ? fwd2[DATA_LEN-1:0] : V2_from_dsp;
            q1_d[free_idx] = fwd1[DATA_LEN] ? '0 : Q1_from_dsp;
            q2_d[free_idx] = fwd2[DATA_LEN] ? '0 : Q2_from_dsp;
            pc_d[free_idx] = pc_from_dsp;
            imm_d[free_idx] = imm_from_dsp;
            rob_d[free_idx] = rob_id_from_dsp;
        end
        if (flush) busy_d = '0;
    end

    // issue registers load the picked entry, otherwise hold their data
    always_comb begin
        al_valid_d = al_found && !flush;
        br_valid_d = br_found && !flush;
        al_op_d = al_valid_d ? op_q[al_idx] : al_op_q;
        al_o1_d = !al_valid_d ? al_o1_q :
                  op_q[al_idx] == OPENUM_LUI ? '0 :
                  op_q[al_idx] == OPENUM_AUIPC ? DATA_LEN'(pc_q[al_idx]) : v1_q[al_idx];
        al_o2_d = !al_valid_d ? al_o2_q : uses_imm(op_q[al_idx]) ? imm_q[al_idx] : v2_q[al_idx];
        al_pc_d = al_valid_d ? pc_q[al_idx] : al_pc_q;
        al_rob_d = al_valid_d ? rob_q[al_idx] : al_rob_q;
        br_op_d = br_valid_d ? op_q[br_idx] : br_op_q;
        br_o1_d = br_valid_d ? v1_q[br_idx] : br_o1_q;
        br_o2_d = br_valid_d ? v2_q[br_idx] : br_o2_q;
        br_off_d = br_valid_d ? imm_q[br_idx] : br_off_q;
        br_pc_d = br_valid_d ? pc_q[br_idx] : br_pc_q;
        br_rob_d = br_valid_d ? rob_q[br_idx] : br_rob_q;
    end

    // busy bits are the only entry state that needs a reset
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;
    end

    // entry payload registers
    always_ff @(posedge clk) begin
        op_q <= op_d;
        v1_q <= v1_d;
        v2_q <= v2_d;
        q1_q <= q1_d;
        q2_q <= q2_d;
        pc_q <= pc_d;
        imm_q <= imm_d;
        rob_q <= rob_d;
    end

    // issue output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            al_valid_q <= 1'b0;
            al_op_q <= '0;
            al_o1_q <= '0;
            al_o2_q <= '0;
            al_pc_q <= '0;
            al_rob_q <= '0;
            br_valid_q <= 1'b0;
            br_op_q <= '0;
            br_o1_q <= '0;
            br_o2_q <= '0;
            br_off_q <= '0;
            br_pc_q <= '0;
            br_rob_q <= '0;
        end else begin
            al_valid_q <= al_valid_d;
            al_op_q <= al_op_d;
            al_o1_q <= al_o1_d;
            al_o2_q <= al_o2_d;
            al_pc_q <= al_pc_d;
            al_rob_q <= al_rob_d;
            br_valid_q <= br_valid_d;
            br_op_q <= br_op_d;
            br_o1_q <= br_o1_d;
            br_o2_q <= br_o2_d;
            br_off_q <= br_off_d;
            br_pc_q <= br_pc_d;
            br_rob_q <= br_rob_d;
        end
    end

    assign al_valid = al_valid_q;
    assign openum_to_al = al_op_q;
    assign oprand1_to_al = al_o1_q;
    assign oprand2_to_al = al_o2_q;
    assign pc_to_al = al_pc_q;
    assign rob_id_to_al = al_rob_q;
    assign br_valid = br_valid_q;
    assign openum_to_br = br_op_q;
    assign oprand1_to_br = br_o1_q;
    assign oprand2_to_br = br_o2_q;
    assign offset_to_br = br_off_q;
    assign pc_to_br = br_pc_q;
    assign rob_id_to_br = br_rob_q;
endmodule

// File: tb/tb_rs_wakeup_select.sv
// tb_rs_wakeup_select: directed vectors and multi-cycle sequences for the reservation station
module tb_rs_wakeup_select;
    import rs_wakeup_select_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, dsp_valid;
    logic [5:0]  openum_from_dsp;
    logic [31:0] V1_from_dsp, V2_from_dsp, pc_from_dsp, imm_from_dsp;
    logic [3:0]  Q1_from_dsp, Q2_from_dsp, rob_id_from_dsp;
    logic        full_to_dsp;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        al_valid, br_valid;
    logic [5:0]  openum_to_al, openum_to_br;
    logic [31:0] oprand1_to_al, oprand2_to_al, pc_to_al;
    logic [31:0] oprand1_to_br, oprand2_to_br, offset_to_br, pc_to_br;
    logic [3:0]  rob_id_to_al, rob_id_to_br;

    int checks = 0;
    int failures = 0;

    rs_wakeup_select dut (
        .clk(clk), .rst(rst), .flush(flush), .dsp_valid(dsp_valid),
        .openum_from_dsp(openum_from_dsp), .V1_from_dsp(V1_from_dsp), .V2_from_dsp(V2_from_dsp),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp), .pc_from_dsp(pc_from_dsp),
        .imm_from_dsp(imm_from_dsp), .rob_id_from_dsp(rob_id_from_dsp), .full_to_dsp(full_to_dsp),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .al_valid(al_valid), .openum_to_al(openum_to_al), .oprand1_to_al(oprand1_to_al),
        .oprand2_to_al(oprand2_to_al), .pc_to_al(pc_to_al), .rob_id_to_al(rob_id_to_al),
        .br_valid(br_valid), .openum_to_br(openum_to_br), .oprand1_to_br(oprand1_to_br),
        .oprand2_to_br(oprand2_to_br), .offset_to_br(offset_to_br), .pc_to_br(pc_to_br),
        .rob_id_to_br(rob_id_to_br)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] v1, v2, pc, imm;
        logic [3:0]  rob;
        logic        is_br;
        logic [31:0] o1, o2;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        dsp_valid = 1'b0;
        flush = 1'b0;
        cdb_valid = '0;
    endtask

    task automatic dsp(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] q1,
                       input logic [31:0] v2, input logic [3:0] q2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [3:0] rob);
        dsp_valid = 1'b1;
        openum_from_dsp = op;
        V1_from_dsp = v1;
        Q1_from_dsp = q1;
        V2_from_dsp = v2;
        Q2_from_dsp = q2;
        pc_from_dsp = pc;
        imm_from_dsp = imm;
        rob_id_from_dsp = rob;
    endtask

    task automatic cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*4 +: 4] = tag;
        cdb_value[p*32 +: 32] = val;
    endtask

    initial begin
        int n, bad, seen;
        vecs[0] = '{OPENUM_ADDI,  32'd5,  32'd99, 32'h100, 32'd7,         4'd3,  1'b0, 32'd5,     32'd7};
        vecs[1] = '{OPENUM_LUI,   32'd5,  32'd99, 32'h200, 32'h12345000,  4'd4,  1'b0, 32'd0,     32'h12345000};
        vecs[2] = '{OPENUM_AUIPC, 32'd5,  32'd99, 32'h300, 32'h1000,      4'd5,  1'b0, 32'h300,   32'h1000};
        vecs[3] = '{OPENUM_ADD,   32'd11, 32'd22, 32'h304, 32'd7,         4'd6,  1'b0, 32'd11,    32'd22};
        vecs[4] = '{OPENUM_SRAI,  32'd8,  32'd22, 32'h308, 32'd3,         4'd7,  1'b0, 32'd8,     32'd3};
        vecs[5] = '{OPENUM_JAL,   32'd1,  32'd2,  32'h30c, 32'd8,         4'd8,  1'b0, 32'd1,     32'd2};
        vecs[6] = '{OPENUM_BEQ,   32'd9,  32'd9,  32'h500, 32'h40,        4'd9,  1'b1, 32'd9,     32'd9};
        vecs[7] = '{OPENUM_BGEU,  32'd3,  32'd4,  32'h600, 32'hFFFFFFF8,  4'd10, 1'b1, 32'd3,     32'd4};
        vecs[8] = '{OPENUM_SLTIU, 32'd1,  32'd2,  32'h700, 32'd100,       4'd11, 1'b0, 32'd1,     32'd100};
        vecs[9] = '{OPENUM_SW,    32'd12, 32'd34, 32'h704, 32'd16,        4'd12, 1'b0, 32'd12,    32'd34};

        rst = 1'b1;
        quiet;
        dsp(6'd0, 0, 0, 0, 0, 0, 0, 0);
        dsp_valid = 1'b0;
        cdb_tag = '0;
        cdb_value = '0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_al_valid", al_valid, 0);
        chk("rst_br_valid", br_valid, 0);
        chk("rst_full", full_to_dsp, 0);
        chk("rst_op1_al", oprand1_to_al, 0);
        chk("rst_rob_al", rob_id_to_al, 0);
        chk("rst_pc_br", pc_to_br, 0);

        for (int k = 0; k < 10; k++) begin
            dsp(vecs[k].op, vecs[k].v1, 0, vecs[k].v2, 0, vecs[k].pc, vecs[k].imm, vecs[k].rob);
            tick;
            quiet;
            chk($sformatf("v%0d_no_early_issue", k), {al_valid, br_valid}, 0);
            tick;
            chk($sformatf("v%0d_al_valid", k), al_valid, !vecs[k].is_br);
            chk($sformatf("v%0d_br_valid", k), br_valid, vecs[k].is_br);
            if (vecs[k].is_br) begin
                chk($sformatf("v%0d_br_op1", k), oprand1_to_br, vecs[k].o1);
                chk($sformatf("v%0d_br_op2", k), oprand2_to_br, vecs[k].o2);
                chk($sformatf("v%0d_br_off", k), offset_to_br, vecs[k].imm);
                chk($sformatf("v%0d_br_pc", k), pc_to_br, vecs[k].pc);
                chk($sformatf("v%0d_br_rob", k), rob_id_to_br, vecs[k].rob);
            end else begin
                chk($sformatf("v%0d_al_op1", k), oprand1_to_al, vecs[k].o1);
                chk($sformatf("v%0d_al_op2", k), oprand2_to_al, vecs[k].o2);
                chk($sformatf("v%0d_al_pc", k), pc_to_al, vecs[k].pc);
                chk($sformatf("v%0d_al_rob", k), rob_id_to_al, vecs[k].rob);
            end
            tick;
            chk($sformatf("v%0d_freed", k), {al_valid, br_valid, full_to_dsp}, 0);
        end

        dsp(OPENUM_ADD, 0, 2, 4, 0, 32'h10, 0, 5);
        tick;
        quiet;
        tick;
        chk("wake_wait1", al_valid, 0);
        tick;
        chk("wake_wait2", al_valid, 0);
        cdb(1, 2, 10);
        tick;
        quiet;
        chk("wake_no_same_edge", al_valid, 0);
        tick;
        chk("wake_al_valid", al_valid, 1);
        chk("wake_op1", oprand1_to_al, 10);
        chk("wake_op2", oprand2_to_al, 4);
        chk("wake_rob", rob_id_to_al, 5);

        dsp(OPENUM_BEQ, 0, 5, 7, 0, 32'h80, 32'h20, 6);
        cdb(0, 5, 9);
        tick;
        quiet;
        chk("fwd_br_not_yet", br_valid, 0);
        tick;
        chk("fwd_br_valid", br_valid, 1);
        chk("fwd_br_op1", oprand1_to_br, 9);
        chk("fwd_br_op2", oprand2_to_br, 7);
        chk("fwd_br_off", offset_to_br, 32'h20);
        chk("fwd_br_pc", pc_to_br, 32'h80);
        chk("fwd_br_rob", rob_id_to_br, 6);
        tick;

        dsp(OPENUM_ADD, 0, 3, 1, 0, 0, 0, 7);
        tick;
        dsp(OPENUM_BEQ, 0, 3, 2, 0, 32'h90, 4, 8);
        tick;
        quiet;
        chk("dual_none_yet", {al_valid, br_valid}, 0);
        cdb(0, 3, 32'h33);
        tick;
        quiet;
        tick;
        chk("dual_al_valid", al_valid, 1);
        chk("dual_br_valid", br_valid, 1);
        chk("dual_al_rob", rob_id_to_al, 7);
        chk("dual_br_rob", rob_id_to_br, 8);
        chk("dual_al_op1", oprand1_to_al, 32'h33);
        chk("dual_br_op1", oprand1_to_br, 32'h33);
        tick;

        for (int i = 0; i < 3; i++) begin
            dsp(OPENUM_ADD, 0, 4, 0, 0, 0, 0, 4'(i + 1));
            tick;
        end
        quiet;
        cdb(0, 4, 32'h44);
        tick;
        quiet;
        chk("order_none_yet", al_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("order_valid%0d", i), al_valid, 1);
            chk($sformatf("order_rob%0d", i), rob_id_to_al, i + 1);
        end
        tick;
        chk("order_done", al_valid, 0);

        dsp(OPENUM_ADD, 0, 6, 0, 0, 0, 0, 2);
        tick;
        quiet;
        cdb(0, 6, 32'h60);
        cdb(1, 6, 32'h61);
        tick;
        quiet;
        tick;
        chk("dup_tag_valid", al_valid, 1);
        chk("dup_tag_low_port", oprand1_to_al, 32'h60);

        dsp(OPENUM_ADD, 32'h5, 0, 32'h6, 0, 0, 0, 3);
        cdb(0, 0, 32'h99);
        tick;
        quiet;
        tick;
        chk("tag0_valid", al_valid, 1);
        chk("tag0_ignored", oprand1_to_al, 32'h5);
        tick;

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_not_full%0d", i), full_to_dsp, 0);
            dsp(OPENUM_ADD, 0, 1, 32'(i), 0, 0, 0, 4'((i % 15) + 1));
            tick;
        end
        chk("fill_full", full_to_dsp, 1);
        dsp(OPENUM_ADD, 32'hDEAD, 0, 0, 0, 0, 0, 14);
        tick;
        quiet;
        chk("drop_full", full_to_dsp, 1);
        chk("drop_no_issue", al_valid, 0);
        cdb(0, 1, 32'h77);
        tick;
        quiet;
        chk("drain_wake_still_full", full_to_dsp, 1);
        chk("drain_wake_no_issue", al_valid, 0);
        n = 0;
        bad = 0;
        for (int c = 0; c < 24; c++) begin
            tick;
            if (c == 0) begin
                chk("drain_first_al", al_valid, 1);
                chk("drain_full_release", full_to_dsp, 0);
            end
            if (al_valid) begin
                if (oprand1_to_al !== 32'h77 || oprand2_to_al !== 32'(n)) bad++;
                n++;
            end
        end
        chk("drain_count", n, 16);
        chk("drain_order_errors", bad, 0);

        for (int i = 0; i < 8; i++) begin
            dsp(OPENUM_ADD, 32'hBAD0 + 32'(i), 2, 0, 0, 0, 0, 4'(i + 1));
            tick;
        end
        quiet;
        chk("flush_pre_none", al_valid, 0);
        flush = 1'b1;
        dsp(OPENUM_ADDI, 32'hF00, 0, 0, 0, 0, 1, 9);
        cdb(0, 2, 32'h22);
        tick;
        quiet;
        chk("flush_al_valid", al_valid, 0);
        chk("flush_br_valid", br_valid, 0);
        chk("flush_full", full_to_dsp, 0);
        chk("flush_hold_op1", oprand1_to_al, 32'h77);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (al_valid || br_valid) seen++;
        end
        chk("flush_never_issued", seen, 0);

        dsp(OPENUM_ADDI, 32'd1, 0, 0, 0, 0, 32'd2, 15);
        tick;
        quiet;
        tick;
        chk("post_flush_al", al_valid, 1);
        chk("post_flush_rob", rob_id_to_al, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
